dma_address: RTL and testbench
==============================

# dma_address

Byte-stream DMA bridge between an 8-bit CPU data port and a 4-bit memory data port, with a 32-bit address/length descriptor forwarded from CPU side to memory side. Per transfer it accepts one descriptor from the CPU, forwards it to memory, then moves `len` bytes in the direction selected by `mode`. Each byte is split into, or assembled from, two nibbles, low nibble first. It sits between the CPU model and the memory model in the DMA subsystem.

## Interface
- No parameters.
- `clk` in 1: single clock; all state changes on its rising edge.
- `resetn` in 1: synchronous, active-high reset (1 = reset, sampled on `clk` rising edge).
- `mode` in 1: 1 = CPU→MEM, 0 = MEM→CPU; sampled at the descriptor handshake.
- `address_in_valid` in 1: CPU presents a valid descriptor.
- `address_in_enable` out 1: DMA ready to accept a descriptor.
- `addr_in` in 32: descriptor address from CPU.
- `len_in` in 32: descriptor byte count from CPU.
- `address_out_valid` out 1: DMA presents the descriptor to MEM.
- `address_out_enable` in 1: MEM ready to accept the descriptor.
- `addr_out` out 32: latched address to MEM.
- `len_out` out 32: latched length to MEM.
- `cpu_to_dma_valid` in 1: CPU byte on `cpu_data_out` is valid.
- `cpu_to_dma_enable` out 1: DMA ready for a CPU byte.
- `cpu_data_out` in 8: byte from CPU.
- `dma_to_cpu_valid` out 1: `cpu_data_in` is valid.
- `dma_to_cpu_enable` in 1: CPU ready to receive.
- `cpu_data_in` out 8: byte to CPU.
- `mem_to_dma_valid` in 1: MEM nibble on `mem_data_out` is valid.
- `mem_to_dma_enable` out 1: DMA ready for a MEM nibble.
- `mem_data_out` in 4: nibble from MEM.
- `dma_to_mem_valid` out 1: `mem_data_in` is valid.
- `dma_to_mem_enable` in 1: MEM ready to receive.
- `mem_data_in` out 4: nibble to MEM.

## Operation
- Handshake rule: a transfer occurs on a rising edge where the valid and the matching enable are both 1. Nothing else moves data.
- Internal registers:
  - `addr_r`[32], `len_r`[32], `dir_r`[1].
  - `buf`[8] byte buffer.
  - `cnt`[32] bytes completed.
- State machine (Moore; each handshake output is 1 only in its listed state, 0 elsewhere):
  - ADDR_IN: `address_in_enable`=1. On handshake, latch `addr_r`←`addr_in`, `len_r`←`len_in`, `dir_r`←`mode`, `cnt`←0, then go to ADDR_OUT.
  - ADDR_OUT: `address_out_valid`=1. On handshake: if `len_r`==0 go to ADDR_IN; else go to C_FILL if `dir_r`=1, or M_LO if `dir_r`=0.
  - C_FILL (CPU→MEM): `cpu_to_dma_enable`=1. On handshake `buf`←`cpu_data_out`, go to W_LO.
  - W_LO: `dma_to_mem_valid`=1, `mem_data_in`=`buf[3:0]`. On handshake go to W_HI.
  - W_HI: `dma_to_mem_valid`=1, `mem_data_in`=`buf[7:4]`. On handshake `cnt`++; go to ADDR_IN if `cnt`+1==`len_r`, else to C_FILL.
  - M_LO (MEM→CPU): `mem_to_dma_enable`=1. On handshake `buf[3:0]`←`mem_data_out`, go to M_HI.
  - M_HI: `mem_to_dma_enable`=1. On handshake `buf[7:4]`←`mem_data_out`, go to C_OUT.
  - C_OUT: `dma_to_cpu_valid`=1, `cpu_data_in`=`buf`. On handshake `cnt`++; go to ADDR_IN if `cnt`+1==`len_r`, else to M_LO.
- `addr_out`=`addr_r` and `len_out`=`len_r` at all times. They stay stable from the descriptor handshake until the next one.
- `mem_data_in`=`buf[3:0]` outside W_HI; `cpu_data_in`=`buf` always.
- `mode` changes after the descriptor handshake are ignored until the next descriptor.
- Valid inputs in non-matching states are ignored, and no data is consumed.
- `cnt` compare is 32-bit unsigned; `len_r` up to 2^32−1 is supported with no wrap before completion.

## Timing
- Reset (`resetn`=1 at an edge):
  - State → ADDR_IN; `addr_r`, `len_r`, `buf`, `cnt`, `dir_r` → 0.
  - While `resetn`=1, all valid/enable outputs are forced to 0. Data outputs are 0.
  - First cycle after release: `address_in_enable`=1.
- Reset mid-transfer aborts the transfer immediately. Partial byte and count are discarded.
- Each state lasts ≥1 cycle; a handshake takes effect at the edge and the next state's outputs appear in the following cycle.
- Minimum cost per byte is 3 cycles. Descriptor overhead is 2 cycles.
- CPU→MEM: byte accepted at edge k → low nibble valid from cycle k+1 → high nibble no earlier than k+2.
- MEM→CPU: high nibble accepted at edge k → byte valid on CPU side from cycle k+1.
- Valid outputs hold, with stable data, until their handshake completes; no timeout.

## Test plan
- Reset: hold `resetn`=1 for 2 cycles → all valid/enable = 0, `addr_out`=`len_out`=0. Release → `address_in_enable`=1.
- Descriptor: `addr_in`=0x12345678, `len_in`=2, `mode`=1, with `address_out_enable` held 0 for 3 cycles → `address_out_valid` stays 1 with `addr_out`=0x12345678, `len_out`=2 until MEM accepts.
- CPU→MEM, `len`=2, bytes 0xA5, 0x3C, random ready/valid → MEM sees nibbles 5, A, C, 3 in that order. Then `address_in_enable`=1, and no further CPU bytes are accepted.
- MEM→CPU, `len`=1, MEM nibbles 0x7 then 0xE → `cpu_data_in`=0xE7 with `dma_to_cpu_valid`=1 held until `dma_to_cpu_enable`. Then back to ADDR_IN.
- `len_in`=0 → after the descriptor handshake, returns to ADDR_IN with no data handshakes.
- Assert `resetn` in W_HI → next cycle all valids 0. After release, a new descriptor is required and the old byte is not resent.

Source files
------------

// File: rtl/dma_address.sv
// dma_address: descriptor-driven byte/nibble DMA bridge.
// Takes one address/length descriptor from the CPU side and passes it on to
// the memory side. It then moves len bytes between the 8-bit CPU port and the
// 4-bit memory port. Each byte travels as two nibbles, low nibble first.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ADDR_IN  | idle, waiting for a CPU descriptor
// ADDR_OUT | presenting the latched descriptor to memory
// C_FILL   | CPU->MEM: waiting for the next CPU byte
// W_LO     | CPU->MEM: offering the low nibble of buf to memory
// W_HI     | CPU->MEM: offering the high nibble of buf to memory
// M_LO     | MEM->CPU: waiting for the low nibble from memory
// M_HI     | MEM->CPU: waiting for the high nibble from memory
// C_OUT    | MEM->CPU: offering the assembled byte to the CPU
module dma_address (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mode,
  input  logic        address_in_valid,
  output logic        address_in_enable,
  input  logic [31:0] addr_in,
  input  logic [31:0] len_in,
  output logic        address_out_valid,
  input  logic        address_out_enable,
  output logic [31:0] addr_out,
  output logic [31:0] len_out,
  input  logic        cpu_to_dma_valid,
  output logic        cpu_to_dma_enable,
  input  logic [7:0]  cpu_data_out,
  output logic        dma_to_cpu_valid,
  input  logic        dma_to_cpu_enable,
  output logic [7:0]  cpu_data_in,
  input  logic        mem_to_dma_valid,
  output logic        mem_to_dma_enable,
  input  logic [3:0]  mem_data_out,
  output logic        dma_to_mem_valid,
  input  logic        dma_to_mem_enable,
  output logic [3:0]  mem_data_in
);

  localparam logic [2:0] ADDR_IN  = 3'd0;
  localparam logic [2:0] ADDR_OUT = 3'd1;
  localparam logic [2:0] C_FILL   = 3'd2;
  localparam logic [2:0] W_LO     = 3'd3;
  localparam logic [2:0] W_HI     = 3'd4;
  localparam logic [2:0] M_LO     = 3'd5;
  localparam logic [2:0] M_HI     = 3'd6;
  localparam logic [2:0] C_OUT    = 3'd7;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] len_q, len_d;
  logic        dir_q, dir_d;
  logic [7:0]  buf_q, buf_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] cnt_inc;
  logic        last_byte;

  // cnt never exceeds len_q - 1 while a byte is in flight, so the increment
  // cannot wrap even when len_q is 2^32-1.
  assign cnt_inc   = cnt_q + 32'd1;
  assign last_byte = (cnt_inc == len_q);

  // Next-state and datapath updates; every transition needs a full handshake.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    dir_d   = dir_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    case (state_q)
      ADDR_IN: begin
        if (address_in_valid) begin
          addr_d  = addr_in;
          len_d   = len_in;
          dir_d   = mode;
          cnt_d   = 32'd0;
          state_d = ADDR_OUT;
        end
      end
      ADDR_OUT: begin
        if (address_out_enable) begin
          if (len_q == 32'd0) begin
            state_d = ADDR_IN;
          end else if (dir_q) begin
            state_d = C_FILL;
          end else begin
            state_d = M_LO;
          end
        end
      end
      C_FILL: begin
        if (cpu_to_dma_valid) begin
          buf_d   = cpu_data_out;
          state_d = W_LO;
        end
      end
      W_LO: begin
        if (dma_to_mem_enable) begin
          state_d = W_HI;
        end
      end
      W_HI: begin
        if (dma_to_mem_enable) begin
          cnt_d   = cnt_inc;
          state_d = last_byte ? ADDR_IN : C_FILL;
        end
      end
      M_LO: begin
        if (mem_to_dma_valid) begin
          buf_d[3:0] = mem_data_out;
          state_d    = M_HI;
        end
      end
      M_HI: begin
        if (mem_to_dma_valid) begin
          buf_d[7:4] = mem_data_out;
          state_d    = C_OUT;
        end
      end
      C_OUT: begin
        if (dma_to_cpu_enable) begin
          cnt_d   = cnt_inc;
          state_d = last_byte ? ADDR_IN : M_LO;
        end
      end
      default: begin
        state_d = ADDR_IN;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial byte and count.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= ADDR_IN;
      addr_q  <= 32'd0;
      len_q   <= 32'd0;
      dir_q   <= 1'b0;
      buf_q   <= 8'd0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore outputs. While reset is asserted, every output is gated to 0 at once,
  // before the reset edge is reached.
  always_comb begin
    address_in_enable = 1'b0;
    address_out_valid = 1'b0;
    cpu_to_dma_enable = 1'b0;
    dma_to_cpu_valid  = 1'b0;
    mem_to_dma_enable = 1'b0;
    dma_to_mem_valid  = 1'b0;
    addr_out          = 32'd0;
    len_out           = 32'd0;
    cpu_data_in       = 8'd0;
    mem_data_in       = 4'd0;
    if (!resetn) begin
      addr_out    = addr_q;
      len_out     = len_q;
      cpu_data_in = buf_q;
      mem_data_in = (state_q == W_HI) ? buf_q[7:4] : buf_q[3:0];
      case (state_q)
        ADDR_IN:  address_in_enable = 1'b1;
        ADDR_OUT: address_out_valid = 1'b1;
        C_FILL:   cpu_to_dma_enable = 1'b1;
        W_LO:     dma_to_mem_valid  = 1'b1;
        W_HI:     dma_to_mem_valid  = 1'b1;
        M_LO:     mem_to_dma_enable = 1'b1;
        M_HI:     mem_to_dma_enable = 1'b1;
        C_OUT:    dma_to_cpu_valid  = 1'b1;
        default:  address_in_enable = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_address.sv
// tb_dma_address: directed vector table plus hand-written corner sequences.
module tb_dma_address;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        mode;
  logic        address_in_valid;
  logic        address_in_enable;
  logic [31:0] addr_in;
  logic [31:0] len_in;
  logic        address_out_valid;
  logic        address_out_enable;
  logic [31:0] addr_out;
  logic [31:0] len_out;
  logic        cpu_to_dma_valid;
  logic        cpu_to_dma_enable;
  logic [7:0]  cpu_data_out;
  logic        dma_to_cpu_valid;
  logic        dma_to_cpu_enable;
  logic [7:0]  cpu_data_in;
  logic        mem_to_dma_valid;
  logic        mem_to_dma_enable;
  logic [3:0]  mem_data_out;
  logic        dma_to_mem_valid;
  logic        dma_to_mem_enable;
  logic [3:0]  mem_data_in;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  dma_address dut (
    .clk                (clk),
    .resetn             (resetn),
    .mode               (mode),
    .address_in_valid   (address_in_valid),
    .address_in_enable  (address_in_enable),
    .addr_in            (addr_in),
    .len_in             (len_in),
    .address_out_valid  (address_out_valid),
    .address_out_enable (address_out_enable),
    .addr_out           (addr_out),
    .len_out            (len_out),
    .cpu_to_dma_valid   (cpu_to_dma_valid),
    .cpu_to_dma_enable  (cpu_to_dma_enable),
    .cpu_data_out       (cpu_data_out),
    .dma_to_cpu_valid   (dma_to_cpu_valid),
    .dma_to_cpu_enable  (dma_to_cpu_enable),
    .cpu_data_in        (cpu_data_in),
    .mem_to_dma_valid   (mem_to_dma_valid),
    .mem_to_dma_enable  (mem_to_dma_enable),
    .mem_data_out       (mem_data_out),
    .dma_to_mem_valid   (dma_to_mem_valid),
    .dma_to_mem_enable  (dma_to_mem_enable),
    .mem_data_in        (mem_data_in)
  );

  // handshake output bits: {ain_en, aout_v, c2d_en, d2c_v, m2d_en, d2m_v}
  localparam logic [5:0] H_NONE = 6'b000000;
  localparam logic [5:0] H_AIN  = 6'b100000;
  localparam logic [5:0] H_AOUT = 6'b010000;
  localparam logic [5:0] H_CF   = 6'b001000;
  localparam logic [5:0] H_CO   = 6'b000100;
  localparam logic [5:0] H_M    = 6'b000010;
  localparam logic [5:0] H_W    = 6'b000001;

  typedef struct {
    logic        rst;
    logic        md;
    logic        ain_v;
    logic [31:0] addr;
    logic [31:0] len;
    logic        aout_en;
    logic        c2d_v;
    logic [7:0]  cdat;
    logic        d2c_en;
    logic        m2d_v;
    logic [3:0]  mdat;
    logic        d2m_en;
    logic [5:0]  hs;
    logic [31:0] aout;
    logic [31:0] lout;
    logic [7:0]  cin;
    logic [3:0]  min;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [5:0] hs_now();
    return {address_in_enable, address_out_valid, cpu_to_dma_enable,
            dma_to_cpu_valid, mem_to_dma_enable, dma_to_mem_valid};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    mode               = 1'b0;
    address_in_valid   = 1'b0;
    addr_in            = 32'd0;
    len_in             = 32'd0;
    address_out_enable = 1'b0;
    cpu_to_dma_valid   = 1'b0;
    cpu_data_out       = 8'd0;
    dma_to_cpu_enable  = 1'b0;
    mem_to_dma_valid   = 1'b0;
    mem_data_out       = 4'd0;
    dma_to_mem_enable  = 1'b0;
  endtask

  task automatic addv(input logic rst, input logic md, input logic ain_v,
                      input logic [31:0] addr, input logic [31:0] len,
                      input logic aout_en, input logic c2d_v, input logic [7:0] cdat,
                      input logic d2c_en, input logic m2d_v, input logic [3:0] mdat,
                      input logic d2m_en, input logic [5:0] hs, input logic [31:0] aout,
                      input logic [31:0] lout, input logic [7:0] cin, input logic [3:0] min);
    vec_t v;
    v.rst = rst; v.md = md; v.ain_v = ain_v; v.addr = addr; v.len = len;
    v.aout_en = aout_en; v.c2d_v = c2d_v; v.cdat = cdat; v.d2c_en = d2c_en;
    v.m2d_v = m2d_v; v.mdat = mdat; v.d2m_en = d2m_en; v.hs = hs;
    v.aout = aout; v.lout = lout; v.cin = cin; v.min = min;
    vecs.push_back(v);
  endtask

  // Present a descriptor and get it through both handshakes, with a bound on each.
  task automatic send_desc(input logic [31:0] a, input logic [31:0] l, input logic m);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      idle();
      address_in_valid = 1'b1;
      addr_in = a;
      len_in = l;
      mode = m;
      #1;
      if (address_in_enable) ok = 1'b1;
    end
    check("desc_in_accept", {31'd0, ok}, 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      idle();
      address_out_enable = 1'b1;
      #1;
      if (address_out_valid) ok = 1'b1;
    end
    check("desc_out_accept", {31'd0, ok}, 32'd1);
    check("desc_out_addr", addr_out, a);
    check("desc_out_len", len_out, l);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bytes[2];
    logic [3:0] exp_nib[4];
    logic [3:0] got[$];
    int bi;

    idle();
    resetn = 1'b1;

    // rst md ain addr len aout c2d cdat d2c m2d mdat d2m | hs aout lout cin min
    addv(1,0,0,32'h0,32'h0,0,0,8'h00,0,0,4'h0,0, H_NONE,32'h0,32'h0,8'h00,4'h0);
    addv(1,1,1,32'hFFFFFFFF,32'h5,1,1,8'hFF,1,1,4'hF,1, H_NONE,32'h0,32'h0,8'h00,4'h0);
    addv(0,1,1,32'h12345678,32'h2,0,0,8'h00,0,0,4'h0,0, H_AIN,32'h0,32'h0,8'h00,4'h0);
    addv(0,0,0,32'h0,32'h0,0,0,8'h00,0,0,4'h0,0, H_AOUT,32'h12345678,32'h2,8'h00,4'h0);
    addv(0,0,0,32'h0,32'h0,0,0,8'h00,0,0,4'h0,0, H_AOUT,32'h12345678,32'h2,8'h00,4'h0);
    addv(0,0,0,32'h0,32'h0,0,0,8'h00,0,0,4'h0,0, H_AOUT,32'h12345678,32'h2,8'h00,4'h0);
    addv(0,0,0,32'h0,32'h0,1,0,8'h00,0,0,4'h0,0, H_AOUT,32'h12345678,32'h2,8'h00,4'h0);
    addv(0,0,0,32'h0,32'h0,0,1,8'hA5,0,1,4'hF,0, H_CF,32'h12345678,32'h2,8'h00,4'h0);
    addv(0,0,0,32'h0,32'h0,0,1,8'h3C,0,0,4'h0,0, H_W,32'h12345678,32'h2,8'hA5,4'h5);
    addv(0,0,0,32'h0,32'h0,0,0,8'h00,0,0,4'h0,1, H_W,32'h12345678,32'h2,8'hA5,4'h5);
    addv(0,0,0,32'h0,32'h0,0,0,8'h00,0,0,4'h0,1, H_W,32'h12345678,32'h2,8'hA5,4'hA);
    addv(0,0,0,32'h0,32'h0,0,1,8'h3C,0,0,4'h0,0, H_CF,32'h12345678,32'h2,8'hA5,4'h5);
    addv(0,0,0,32'h0,32'h0,0,0,8'h00,0,0,4'h0,1, H_W,32'h12345678,32'h2,8'h3C,4'hC);
    addv(0,0,0,32'h0,32'h0,0,0,8'h00,0,0,4'h0,1, H_W,32'h12345678,32'h2,8'h3C,4'h3);
    addv(0,0,0,32'h0,32'h0,0,1,8'h99,0,0,4'h0,0, H_AIN,32'h12345678,32'h2,8'h3C,4'hC);
    addv(0,0,1,32'hCAFE0000,32'h1,0,0,8'h00,0,0,4'h0,0, H_AIN,32'h12345678,32'h2,8'h3C,4'hC);
    addv(0,1,0,32'h0,32'h0,1,0,8'h00,0,0,4'h0,0, H_AOUT,32'hCAFE0000,32'h1,8'h3C,4'hC);
    addv(0,0,0,32'h0,32'h0,0,0,8'h00,0,1,4'h7,0, H_M,32'hCAFE0000,32'h1,8'h3C,4'hC);
    addv(0,0,0,32'h0,32'h0,0,0,8'h00,0,0,4'h0,0, H_M,32'hCAFE0000,32'h1,8'h37,4'h7);
    addv(0,0,0,32'h0,32'h0,0,0,8'h00,0,1,4'hE,0, H_M,32'hCAFE0000,32'h1,8'h37,4'h7);
    addv(0,0,0,32'h0,32'h0,0,0,8'h00,0,1,4'h1,0, H_CO,32'hCAFE0000,32'h1,8'hE7,4'h7);
    addv(0,0,0,32'h0,32'h0,0,0,8'h00,0,0,4'h0,0, H_CO,32'hCAFE0000,32'h1,8'hE7,4'h7);
    addv(0,0,0,32'h0,32'h0,0,0,8'h00,1,0,4'h0,0, H_CO,32'hCAFE0000,32'h1,8'hE7,4'h7);
    addv(0,0,0,32'h0,32'h0,0,0,8'h00,0,0,4'h0,0, H_AIN,32'hCAFE0000,32'h1,8'hE7,4'h7);

    foreach (vecs[i]) begin
      @(negedge clk);
      resetn             = vecs[i].rst;
      mode               = vecs[i].md;
      address_in_valid   = vecs[i].ain_v;
      addr_in            = vecs[i].addr;
      len_in             = vecs[i].len;
      address_out_enable = vecs[i].aout_en;
      cpu_to_dma_valid   = vecs[i].c2d_v;
      cpu_data_out       = vecs[i].cdat;
      dma_to_cpu_enable  = vecs[i].d2c_en;
      mem_to_dma_valid   = vecs[i].m2d_v;
      mem_data_out       = vecs[i].mdat;
      dma_to_mem_enable  = vecs[i].d2m_en;
      #1;
      check($sformatf("vec%0d_hs", i), {26'd0, hs_now()}, {26'd0, vecs[i].hs});
      check($sformatf("vec%0d_addr_out", i), addr_out, vecs[i].aout);
      check($sformatf("vec%0d_len_out", i), len_out, vecs[i].lout);
      check($sformatf("vec%0d_cpu_data_in", i), {24'd0, cpu_data_in}, {24'd0, vecs[i].cin});
      check($sformatf("vec%0d_mem_data_in", i), {28'd0, mem_data_in}, {28'd0, vecs[i].min});
    end

    // CPU->MEM, len 2, random valid/ready on the data ports.
    send_desc(32'h0000_2000, 32'd2, 1'b1);
    bytes[0] = 8'hA5;
    bytes[1] = 8'h3C;
    exp_nib[0] = 4'h5; exp_nib[1] = 4'hA; exp_nib[2] = 4'hC; exp_nib[3] = 4'h3;
    bi = 0;
    got.delete();
    for (int c = 0; c < 300 && got.size() < 4; c++) begin
      @(negedge clk);
      idle();
      cpu_to_dma_valid  = 1'($urandom_range(0, 1));
      cpu_data_out      = (bi < 2) ? bytes[bi] : 8'hEE;
      dma_to_mem_enable = 1'($urandom_range(0, 1));
      #1;
      if (cpu_to_dma_enable && cpu_to_dma_valid) bi++;
      if (dma_to_mem_valid && dma_to_mem_enable) got.push_back(mem_data_in);
    end
    check("rand_nibble_count", got.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) check($sformatf("rand_nibble%0d", i), {28'd0, got[i]}, {28'd0, exp_nib[i]});
    end
    check("rand_bytes_taken", bi, 32'd2);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle();
      cpu_to_dma_valid = 1'b1;
      cpu_data_out = 8'h55;
      #1;
      check($sformatf("post_c2m_hs%0d", c), {26'd0, hs_now()}, {26'd0, H_AIN});
    end

    // Zero-length descriptor: straight back to ADDR_IN, no data handshakes.
    send_desc(32'h0000_1000, 32'd0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle();
      cpu_to_dma_valid  = 1'b1;
      mem_to_dma_valid  = 1'b1;
      dma_to_cpu_enable = 1'b1;
      dma_to_mem_enable = 1'b1;
      #1;
      check($sformatf("len0_hs%0d", c), {26'd0, hs_now()}, {26'd0, H_AIN});
    end

    // Reset asserted while the high nibble is on offer.
    send_desc(32'hABCD_0000, 32'd3, 1'b1);
    @(negedge clk);
    idle();
    cpu_to_dma_valid = 1'b1;
    cpu_data_out = 8'h5A;
    #1;
    check("rst_cfill_hs", {26'd0, hs_now()}, {26'd0, H_CF});
    @(negedge clk);
    idle();
    dma_to_mem_enable = 1'b1;
    #1;
    check("rst_wlo_nib", {28'd0, mem_data_in}, 32'hA);
    @(negedge clk);
    idle();
    #1;
    check("rst_whi_hs", {26'd0, hs_now()}, {26'd0, H_W});
    check("rst_whi_nib", {28'd0, mem_data_in}, 32'h5);
    resetn = 1'b1;
    #1;
    check("rst_gated_hs", {26'd0, hs_now()}, {26'd0, H_NONE});
    check("rst_gated_nib", {28'd0, mem_data_in}, 32'h0);
    check("rst_gated_addr", addr_out, 32'h0);
    @(negedge clk);
    dma_to_mem_enable = 1'b1;
    #1;
    check("rst_held_hs", {26'd0, hs_now()}, {26'd0, H_NONE});
    check("rst_held_len", len_out, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      resetn = 1'b0;
      idle();
      dma_to_mem_enable = 1'b1;
      cpu_to_dma_valid = 1'b1;
      #1;
      check($sformatf("rst_release_hs%0d", c), {26'd0, hs_now()}, {26'd0, H_AIN});
      check($sformatf("rst_release_cin%0d", c), {24'd0, cpu_data_in}, 32'h0);
    end
    send_desc(32'h0BAD_F00D, 32'd1, 1'b0);
    @(negedge clk);
    idle();
    #1;
    check("rst_new_desc_hs", {26'd0, hs_now()}, {26'd0, H_M});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
